// File: rtl/board_io_pkg.sv
// Board-level constants shared by the iCESugar I/O blocks: clock rate,
// time-to-cycle conversions and pin polarities.
package board_io_pkg;

    localparam int CLK_HZ = 12_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int MS_20_CYCLES = ms_to_cycles(20);
    localparam int S_1_CYCLES   = ms_to_cycles(1000);

    // Buttons on this board pull the pin low when pressed.
    localparam bit BTN_ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs; RESET_VAL
// lets each input reset to its own idle level.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: both flops load the idle level on reset so that leaving reset
    // never looks like an input edge to the logic downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounced push-button reader: level, press/release pulses, press count.
// Define BUTTON_LONG_PRESS_EN to build the long-press timer and long_pulse.
module button_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = MS_20_CYCLES,
    parameter int LONG_CYCLES     = S_1_CYCLES,
    parameter bit ACTIVE_LOW      = BTN_ACTIVE_LOW
) (
    input  logic       clki,
    input  logic       rst,
    input  logic       btn_i,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
        $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    logic            btn_s;
    logic            raw_s;
    logic [DB_W-1:0] db_cnt;

    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_btn_sync (
        .clk (clki),
        .rst (rst),
        .d   (btn_i),
        .q   (btn_s)
    );

    assign raw_s = ACTIVE_LOW ? ~btn_s : btn_s;

    // NOTE: all state updates are non-blocking so every register in this
    // block sees the pre-edge value of btn_level and db_cnt.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
            db_cnt        <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (raw_s == btn_level) begin
                // A single agreeing sample restarts the stability window.
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_level <= raw_s;
                db_cnt    <= '0;
                if (raw_s) begin
                    press_pulse <= 1'b1;
                    press_count <= press_count + 8'd1;
                end else begin
                    release_pulse <= 1'b1;
                end
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;
    logic              long_q;

    // hold_cnt saturates at HOLD_LAST; long_done limits it to one pulse per press.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!btn_level) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end else if (!long_done) begin
                long_q    <= 1'b1;
                long_done <= 1'b1;
            end
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10,
// ACTIVE_LOW=1; long-press expectations follow BUTTON_LONG_PRESS_EN.
module tb_button_debounce;

    logic       clki = 1'b0;
    logic       rst;
    logic       btn_i;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int tests = 0;
    int fails = 0;

`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clki          (clki),
        .rst           (rst),
        .btn_i         (btn_i),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clki = ~clki;

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       btn;
        logic       level;
        logic       press;
        logic       rel;
        logic [7:0] count;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Low for low_n cycles then high for high_n cycles; returns pulse counts.
    task automatic press_release(input int low_n, input int high_n,
                                 output int n_press, output int n_rel);
        n_press = 0;
        n_rel   = 0;
        btn_i = 1'b0;
        for (int i = 0; i < low_n; i++) begin
            step();
            n_press += int'(press_pulse);
            n_rel   += int'(release_pulse);
        end
        btn_i = 1'b1;
        for (int i = 0; i < high_n; i++) begin
            step();
            n_press += int'(press_pulse);
            n_rel   += int'(release_pulse);
        end
    endtask

    initial begin
        int press_at, long_at, rel_at, long_n, press_n, rel_n, pulses_bad;

        // Clean press (pin low from cycle 0) then clean release at cycle 8.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};

        btn_i = 1'b1;
        do_reset();
        check("init_level", btn_level, 0);
        check("init_count", press_count, 0);

        for (int i = 0; i < 15; i++) begin
            btn_i = vecs[i].btn;
            step();
            check($sformatf("vec%0d_level", i), btn_level, vecs[i].level);
            check($sformatf("vec%0d_press", i), press_pulse, vecs[i].press);
            check($sformatf("vec%0d_release", i), release_pulse, vecs[i].rel);
            check($sformatf("vec%0d_long", i), long_pulse, 0);
            check($sformatf("vec%0d_count", i), press_count, vecs[i].count);
        end

        // Bounce: 3 low cycles never reach the 4-cycle stability window.
        pulses_bad = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                btn_i = (i < 3) ? 1'b0 : 1'b1;
                step();
                if (btn_level || press_pulse || release_pulse) pulses_bad++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (btn_level || press_pulse || release_pulse) pulses_bad++;
        end
        check("bounce_activity", pulses_bad, 0);
        check("bounce_count", press_count, 1);

        // Boundary: exactly 4 low cycles is accepted.
        press_at = 0;
        rel_at   = 0;
        btn_i    = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) btn_i = 1'b1;
            step();
            if (press_pulse) press_at = i;
            if (release_pulse) rel_at = i;
        end
        check("min_press_at", press_at, 6);
        check("min_release_at", rel_at, 10);
        check("min_press_count", press_count, 2);

        // Long press: held 20 cycles.
        press_at = 0; long_at = 0; rel_at = 0; long_n = 0;
        btn_i = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i == 21) btn_i = 1'b1;
            step();
            if (press_pulse) press_at = i;
            if (release_pulse) rel_at = i;
            if (long_pulse) begin
                long_at = i;
                long_n++;
            end
        end
        check("long_press_at", press_at, 6);
        check("long_release_at", rel_at, 26);
        check("long_pulse_count", long_n, LONG_EN ? 1 : 0);
        check("long_pulse_at", long_at, LONG_EN ? 16 : 0);
        check("long_press_count", press_count, 3);

        // Asynchronous reset mid-press.
        btn_i = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("pre_reset_level", btn_level, 1);
        rst = 1'b1;
        #1;
        check("rst_level", btn_level, 0);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        check("rst_long", long_pulse, 0);
        check("rst_count", press_count, 0);
        check("rst_sync_meta", dut.u_btn_sync.meta, 1);
        check("rst_sync_q", dut.u_btn_sync.q, 1);
        step();
        rst = 1'b0;

        // Button still held across reset release.
        press_at = 0; long_at = 0; long_n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) check("held_first_level", btn_level, 0);
            if (press_pulse) press_at = i;
            if (long_pulse) begin
                long_at = i;
                long_n++;
            end
        end
        check("held_press_at", press_at, 6);
        check("held_long_count", long_n, LONG_EN ? 1 : 0);
        check("held_long_at", long_at, LONG_EN ? 16 : 0);
        check("held_count", press_count, 1);
        btn_i = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Count wrap over 257 presses.
        do_reset();
        pulses_bad = 0;
        for (int n = 1; n <= 257; n++) begin
            press_release(6, 6, press_n, rel_n);
            if (press_n != 1 || rel_n != 1) pulses_bad++;
            if (n == 255) check("wrap_count_255", press_count, 255);
            if (n == 256) check("wrap_count_256", press_count, 0);
        end
        check("wrap_pulse_pairs", pulses_bad, 0);
        check("wrap_count_257", press_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
